// File: rtl/sum_seq_ctrl_if.sv
// rtl/sum_seq_ctrl_if.sv - operand/sum handshake bundle for the serial adder sequencer
interface sum_seq_ctrl_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, sum
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, sum
    );
endinterface

// File: rtl/sum_seq_ctrl.sv
// rtl/sum_seq_ctrl.sv - sequencer feeding a W-bit slice adder LSB-first and reassembling the N-bit sum
module sum_seq_ctrl #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    sum_seq_ctrl_if.slave bus,
    output logic [W-1:0] dp_a,
    output logic [W-1:0] dp_b,
    input  logic [W-1:0] dp_c,
    output logic         dp_rst,
    output logic         busy
);
    localparam int CC = N / W;
    localparam int CW = (CC > 1) ? $clog2(CC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CLR  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  opa_q, opa_d;
    logic [N-1:0]  opb_q, opb_d;
    logic [N-1:0]  res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clr_q, clr_d;

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        clr_d   = clr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    opa_d   = bus.a_in;
                    opb_d   = bus.b_in;
                    clr_d   = 1'b1;
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                clr_d   = 1'b0;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Result fills from the top so the first slice lands at bit 0 after CC shifts.
                res_d = {dp_c, res_q[N-1:W]};
                opa_d = opa_q >> W;
                opb_d = opb_q >> W;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
        end
    end

    // Only registered terms reach dp_rst, keeping the datapath reset glitch-free.
    assign dp_rst        = rst | clr_q;
    assign dp_a          = (state_q == ST_RUN) ? opa_q[W-1:0] : '0;
    assign dp_b          = (state_q == ST_RUN) ? opb_q[W-1:0] : '0;
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = res_q;
    assign busy          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_sum_seq_ctrl.sv
// tb/tb_sum_seq_ctrl.sv - self-checking bench for sum_seq_ctrl with a behavioural slice adder
module tb_sum_seq_ctrl;
    localparam int N  = 16;
    localparam int W  = 4;
    localparam int CC = N / W;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] dp_a, dp_b, dp_c;
    logic         dp_rst;
    logic         busy;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int last_acc = -1000;
    logic done_carry;

    sum_seq_ctrl_if #(.N(N)) bus ();

    sum_seq_ctrl #(.N(N), .W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .dp_a   (dp_a),
        .dp_b   (dp_b),
        .dp_c   (dp_c),
        .dp_rst (dp_rst),
        .busy   (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slice adder with a carry flop cleared by dp_rst
    logic       carry_q;
    logic [W:0] add_full;
    assign add_full = {1'b0, dp_a} + {1'b0, dp_b} + {{W{1'b0}}, carry_q};
    assign dp_c     = add_full[W-1:0];
    always_ff @(posedge clk or posedge dp_rst) begin
        if (dp_rst) carry_q <= 1'b0;
        else        carry_q <= add_full[W];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_junk(input bit junk);
        bus.in_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.a_in     = 16'($urandom);
        bus.b_in     = 16'($urandom);
    endtask

    // Called at a negedge while IDLE; returns at a negedge in IDLE after the sum is taken.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input int stall, input bit junk);
        logic [N-1:0] expv;
        logic [W-1:0] sa, sb;
        int n;
        int acc;
        expv = N'((32'(a) + 32'(b)) % 32'h10000);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        if (last_acc > -1000) check("issue_interval_ge7", 32'((acc - last_acc) >= CC + 3), 1);
        last_acc = acc;
        n = 1;
        check("clr_dp_rst", dp_rst, 1);
        check("clr_busy", busy, 1);
        check("clr_in_ready", bus.in_ready, 0);
        check("clr_dp_a_zero", dp_a, 0);
        drive_junk(junk);
        while (!bus.out_valid && n < 50) begin
            if (n >= 2 && n <= CC + 1) begin
                sa = W'(a >> (W * (n - 2)));
                sb = W'(b >> (W * (n - 2)));
                check("run_dp_a_slice", dp_a, sa);
                check("run_dp_b_slice", dp_b, sb);
                check("run_dp_rst_low", dp_rst, 0);
            end
            @(negedge clk);
            n++;
            drive_junk(junk);
        end
        check("latency_to_out_valid", n, CC + 2);
        done_carry = carry_q;
        check("done_dp_a_zero", dp_a, 0);
        for (int s = 0; s < stall; s++) begin
            bus.out_ready = 1'b0;
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_sum", bus.sum, expv);
            check("stall_in_ready", bus.in_ready, 0);
            @(negedge clk);
            drive_junk(junk);
        end
        check("sum", bus.sum, expv);
        check("out_valid_at_handshake", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("after_handshake_out_valid", bus.out_valid, 0);
        check("after_handshake_in_ready", bus.in_ready, 1);
        check("after_handshake_busy", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_sum", bus.sum, 0);
        check("reset_dp_a", dp_a, 0);
        check("reset_dp_b", dp_b, 0);
        check("reset_dp_rst", dp_rst, 1);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_dp_rst", dp_rst, 0);

        do_op(16'h1234, 16'h0FFF, 0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 0, 1'b0);
        check("wrap_model_carry", done_carry, 1);
        do_op(16'h0000, 16'h0000, 0, 1'b0);
        do_op(16'h8000, 16'h8000, 5, 1'b0);
        do_op(16'h0FFF, 16'h0001, 0, 1'b0);

        // Abort in the second RUN cycle
        bus.in_valid = 1'b1;
        bus.a_in     = 16'h1111;
        bus.b_in     = 16'h2222;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_dp_rst", dp_rst, 1);
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_sum_cleared", bus.sum, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_out_valid", bus.out_valid, 0);
        end
        last_acc = -1000;
        do_op(16'h0001, 16'h0002, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) @(negedge clk);
            do_op(16'($urandom), 16'($urandom), $urandom_range(0, 3), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
